// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU core and its command sequencer:
// opcode values, sequencer FSM encoding and the command error rule.
package alu_pkg;

  localparam logic [7:0] OP_ADD  = 8'd0;
  localparam logic [7:0] OP_SUB  = 8'd1;
  localparam logic [7:0] OP_MUL  = 8'd2;
  localparam logic [7:0] OP_DIV  = 8'd3;
  localparam logic [7:0] OP_AND  = 8'd4;
  localparam logic [7:0] OP_OR   = 8'd5;
  localparam logic [7:0] OP_XOR  = 8'd6;
  localparam logic [7:0] OP_NAND = 8'd7;
  localparam logic [7:0] OP_NOR  = 8'd8;
  localparam logic [7:0] OP_NOT  = 8'd9;
  localparam logic [7:0] OP_MOD  = 8'd10;
  localparam logic [7:0] OP_SHL  = 8'd11;
  localparam logic [7:0] OP_SHR  = 8'd12;
  localparam logic [7:0] OP_MAX  = 8'd12;

  typedef enum logic [1:0] {
    ST_WAIT_OP  = 2'd0,
    ST_WAIT_ARG = 2'd1,
    ST_SETTLE   = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  // A command is rejected when the opcode is out of range or when it asks
  // for a division/modulo by a zero y operand.
  function automatic logic cmd_error(input logic [7:0] opc,
                                     input logic [3:0] y,
                                     input logic [7:0] op_max);
    return (opc > op_max) ||
           (((opc == OP_DIV) || (opc == OP_MOD)) && (y == 4'd0));
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command/response stream between a producer and the ALU command sequencer.
// The sequencer takes the slave side; the command producer / response
// consumer takes the master side.
interface alu_cmd_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Initiator for the 4-bit ALU core. Collects an {opcode, operands} byte pair,
// presents both to the ALU on the same edge, waits SETTLE_CYCLES (1..15),
// captures the result (or an error) and holds it until the response
// handshake. Completed responses are counted modulo 256.
module alu_cmd_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [7:0]  OP_MAX        = alu_pkg::OP_MAX
) (
  input  logic                clk,
  input  logic                rst,
  alu_cmd_sequencer_if.slave  cmd,
  output logic [7:0]          alu_operands,
  output logic [7:0]          alu_opcode,
  input  logic [7:0]          alu_result,
  output logic [7:0]          txn_count
);
  import alu_pkg::*;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] opc_hold;
  logic [3:0] cnt;
  logic       op_xfer;
  logic       arg_xfer;
  logic       capture;
  logic       resp_xfer;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_WAIT_OP;
    else     state <= state_nxt;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    state_nxt     = state;
    cmd.in_ready  = 1'b0;
    cmd.out_valid = 1'b0;
    op_xfer       = 1'b0;
    arg_xfer      = 1'b0;
    capture       = 1'b0;
    resp_xfer     = 1'b0;
    case (state)
      ST_WAIT_OP: begin
        cmd.in_ready = 1'b1;
        if (cmd.in_valid) begin
          op_xfer   = 1'b1;
          state_nxt = ST_WAIT_ARG;
        end
      end
      ST_WAIT_ARG: begin
        cmd.in_ready = 1'b1;
        if (cmd.in_valid) begin
          arg_xfer  = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        cmd.out_valid = 1'b1;
        if (cmd.out_ready) begin
          resp_xfer = 1'b1;
          state_nxt = ST_WAIT_OP;
        end
      end
      default: state_nxt = ST_WAIT_OP;
    endcase
  end

  // Opcode hold, ALU drive, settle counter, result capture and txn counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opc_hold     <= 8'h00;
      alu_operands <= 8'h00;
      alu_opcode   <= 8'h00;
      cnt          <= 4'd0;
      cmd.out_data <= 8'h00;
      cmd.out_err  <= 1'b0;
      txn_count    <= 8'h00;
    end else begin
      if (op_xfer) opc_hold <= cmd.in_data;
      if (arg_xfer) begin
        alu_operands <= cmd.in_data;
        alu_opcode   <= opc_hold;
        cnt          <= SETTLE_LOAD;
      end else if ((state == ST_SETTLE) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        if (cmd_error(alu_opcode, alu_operands[7:4], OP_MAX)) begin
          cmd.out_err  <= 1'b1;
          cmd.out_data <= 8'h00;
        end else begin
          cmd.out_err  <= 1'b0;
          cmd.out_data <= alu_result;
        end
      end
      if (resp_xfer) txn_count <= txn_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: two instances (SETTLE_CYCLES = 1 and 3)
// each driving a behavioural 4-bit ALU responder.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic       clk;
  logic       rst       [2];
  logic [7:0] in_data   [2];
  logic       in_valid  [2];
  logic       out_ready [2];
  logic       in_ready  [2];
  logic [7:0] out_data  [2];
  logic       out_err   [2];
  logic       out_valid [2];
  logic [7:0] alu_ops   [2];
  logic [7:0] alu_opc   [2];
  logic [7:0] txn       [2];

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] alu_model(input logic [7:0] opc, input logic [7:0] ops);
    logic [7:0] x;
    logic [7:0] y;
    x = {4'd0, ops[3:0]};
    y = {4'd0, ops[7:4]};
    case (opc)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_MUL:  return x * y;
      OP_DIV:  return (y == 8'd0) ? 8'hFF : x / y;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_NAND: return {4'd0, ~(x[3:0] & y[3:0])};
      OP_NOR:  return {4'd0, ~(x[3:0] | y[3:0])};
      OP_NOT:  return {4'd0, ~x[3:0]};
      OP_MOD:  return (y == 8'd0) ? 8'hFF : x % y;
      OP_SHL:  return x << y[3:0];
      OP_SHR:  return x >> y[3:0];
      default: return 8'hAA;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_cmd_sequencer_if bus ();
    logic [7:0] result;

    assign bus.in_data   = in_data[g];
    assign bus.in_valid  = in_valid[g];
    assign bus.out_ready = out_ready[g];
    assign in_ready[g]   = bus.in_ready;
    assign out_data[g]   = bus.out_data;
    assign out_err[g]    = bus.out_err;
    assign out_valid[g]  = bus.out_valid;
    assign result        = alu_model(alu_opc[g], alu_ops[g]);

    alu_cmd_sequencer #(
      .SETTLE_CYCLES ((g == 0) ? 1 : 3)
    ) u_dut (
      .clk          (clk),
      .rst          (rst[g]),
      .cmd          (bus.slave),
      .alu_operands (alu_ops[g]),
      .alu_opcode   (alu_opc[g]),
      .alu_result   (result),
      .txn_count    (txn[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input int k, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_data[k]  = b;
    in_valid[k] = 1'b1;
    while (!in_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {7'd0, in_ready[k]}, 8'd1);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
  endtask

  // Called #1 after the operand-accepting edge.
  task automatic expect_resp(input int k, input int s, input logic [7:0] d,
                             input logic e, input logic [7:0] t, input int hold);
    for (int i = 1; i < s; i++) begin
      @(posedge clk);
      #1;
      check("early_valid", {7'd0, out_valid[k]}, 8'd0);
    end
    @(posedge clk);
    #1;
    check("out_valid", {7'd0, out_valid[k]}, 8'd1);
    check("out_data", out_data[k], d);
    check("out_err", {7'd0, out_err[k]}, {7'd0, e});
    check("in_ready_resp", {7'd0, in_ready[k]}, 8'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("hold_valid", {7'd0, out_valid[k]}, 8'd1);
      check("hold_data", out_data[k], d);
      check("hold_err", {7'd0, out_err[k]}, {7'd0, e});
      check("hold_in_ready", {7'd0, in_ready[k]}, 8'd0);
      check("hold_txn", txn[k], 8'(t - 8'd1));
    end
    out_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[k] = 1'b0;
    check("valid_drop", {7'd0, out_valid[k]}, 8'd0);
    check("in_ready_back", {7'd0, in_ready[k]}, 8'd1);
    check("txn_count", txn[k], t);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k]       = 1'b1;
      in_data[k]   = 8'h00;
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_in_ready", {7'd0, in_ready[k]}, 8'd1);
      check("rst_out_valid", {7'd0, out_valid[k]}, 8'd0);
      check("rst_out_err", {7'd0, out_err[k]}, 8'd0);
      check("rst_out_data", out_data[k], 8'h00);
      check("rst_alu_ops", alu_ops[k], 8'h00);
      check("rst_alu_opc", alu_opc[k], 8'h00);
      check("rst_txn", txn[k], 8'h00);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // SETTLE_CYCLES = 1: add 5+3
    send_byte(0, 8'h00);
    send_byte(0, 8'h35);
    expect_resp(0, 1, 8'h08, 1'b0, 8'd1, 0);

    // sub 2-5 with idle cycles between opcode and operands, then mul 15*15
    send_byte(0, 8'h01);
    repeat (3) @(negedge clk);
    check("wait_arg_ready", {7'd0, in_ready[0]}, 8'd1);
    check("wait_arg_no_valid", {7'd0, out_valid[0]}, 8'd0);
    send_byte(0, 8'h52);
    expect_resp(0, 1, 8'hFD, 1'b0, 8'd2, 0);
    send_byte(0, 8'h02);
    send_byte(0, 8'hFF);
    expect_resp(0, 1, 8'hE1, 1'b0, 8'd3, 0);

    // div and mod by zero
    send_byte(0, 8'h03);
    send_byte(0, 8'h07);
    expect_resp(0, 1, 8'h00, 1'b1, 8'd4, 0);
    send_byte(0, 8'h0A);
    send_byte(0, 8'h09);
    expect_resp(0, 1, 8'h00, 1'b1, 8'd5, 0);

    // illegal opcode 0x0D
    send_byte(0, 8'h0D);
    send_byte(0, 8'h11);
    check("settle_opcode", alu_opc[0], 8'h0D);
    check("settle_operands", alu_ops[0], 8'h11);
    expect_resp(0, 1, 8'h00, 1'b1, 8'd6, 0);

    // xor C^3 with out_ready withheld for 5 cycles
    send_byte(0, 8'h06);
    send_byte(0, 8'h3C);
    expect_resp(0, 1, 8'h0F, 1'b0, 8'd7, 5);
    check("ops_held", alu_ops[0], 8'h3C);
    check("opc_held", alu_opc[0], 8'h06);

    // SETTLE_CYCLES = 3
    send_byte(1, 8'h00);
    send_byte(1, 8'h35);
    expect_resp(1, 3, 8'h08, 1'b0, 8'd1, 0);
    send_byte(1, 8'h0D);
    send_byte(1, 8'h11);
    check("settle3_opcode", alu_opc[1], 8'h0D);
    expect_resp(1, 3, 8'h00, 1'b1, 8'd2, 0);

    // reset asserted mid-settle: immediate reset values, no response afterwards
    send_byte(1, 8'h02);
    send_byte(1, 8'h33);
    @(negedge clk);
    rst[1] = 1'b1;
    #1;
    check("arst_in_ready", {7'd0, in_ready[1]}, 8'd1);
    check("arst_out_valid", {7'd0, out_valid[1]}, 8'd0);
    check("arst_out_data", out_data[1], 8'h00);
    check("arst_out_err", {7'd0, out_err[1]}, 8'd0);
    check("arst_alu_ops", alu_ops[1], 8'h00);
    check("arst_alu_opc", alu_opc[1], 8'h00);
    check("arst_txn", txn[1], 8'h00);
    @(negedge clk);
    rst[1] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_no_resp", {7'd0, out_valid[1]}, 8'd0);
    end

    // 256 transactions wrap the counter back to zero
    for (int i = 0; i < 256; i++) begin
      send_byte(1, 8'h00);
      send_byte(1, 8'h00);
      expect_resp(1, 3, 8'h00, 1'b0, 8'(i + 1), 0);
    end
    check("txn_wrap", txn[1], 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
